// File: rtl/video_timing_gen.sv
// Raster timing generator that streams RGB pixels from a show-ahead FIFO once it has filled.
// Optional macro VIDEO_UNDERFLOW_CNT_EN builds a saturating FIFO underflow counter.
module video_timing_gen #(
  parameter int unsigned HDISP  = 800,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 40,
  parameter int unsigned HPULSE = 48,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VFP    = 13,
  parameter int unsigned VPULSE = 3,
  parameter int unsigned VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_rempty,
  input  logic        fifo_rfull,
  output logic        fifo_read,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_blank,
  output logic [23:0] video_rgb,
  output logic        frame_start,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int unsigned VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);

  typedef enum logic [1:0] {WAIT_FIFO, WAIT_FRAME, STREAM} state_t;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_last;
  logic          v_last;
  logic          h_sync;
  logic          v_sync;
  logic          active;
  logic          fifo_ok;
  logic          pixel_ok;
  logic          unused_rdata;
  state_t        state;
  state_t        state_next;

  assign h_last   = (hcnt == HW'(HTOTAL - 1));
  assign v_last   = (vcnt == VW'(VTOTAL - 1));
  assign h_sync   = (hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE));
  assign v_sync   = (vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE));
  assign active   = (hcnt >= HW'(HTOTAL - HDISP)) && (vcnt >= VW'(VTOTAL - VDISP));
  // A FIFO reporting both full and empty is not trusted as full.
  assign fifo_ok  = fifo_rfull && !fifo_rempty;
  assign pixel_ok = fifo_read && !fifo_rempty;
  assign unused_rdata = ^fifo_rdata[31:24];

  // Pixel and line counters; vcnt advances only on the line wrap.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state <= WAIT_FIFO;
    end else begin
      state <= state_next;
    end
  end

  // Streaming only ever starts at a frame origin; once running it never stops until reset.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_FIFO:  if (fifo_ok) state_next = WAIT_FRAME;
      WAIT_FRAME: if (h_last && v_last) state_next = STREAM;
      STREAM:     state_next = STREAM;
      default:    state_next = WAIT_FIFO;
    endcase
  end

  always_comb begin
    fifo_read = 1'b0;
    if (state == STREAM && active) begin
      fifo_read = 1'b1;
    end
  end

  // Video outputs lag the counters by one cycle; an empty FIFO shows black.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      video_hs    <= 1'b1;
      video_vs    <= 1'b1;
      video_blank <= 1'b0;
      video_rgb   <= '0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= ~h_sync;
      video_vs    <= ~v_sync;
      video_blank <= active;
      video_rgb   <= pixel_ok ? fifo_rdata[23:0] : 24'd0;
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

`ifdef VIDEO_UNDERFLOW_CNT_EN
  logic [15:0] uf_q;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      uf_q <= '0;
    end else if (fifo_read && fifo_rempty && (uf_q != 16'hFFFF)) begin
      uf_q <= uf_q + 16'd1;
    end
  end

  assign underflow_cnt = uf_q;
`else
  assign underflow_cnt = 16'd0;
`endif

endmodule
